// File: rtl/key_expand_128.sv
// key_expand_128: AES-128 round-key generator feeding the sigma key-addition stage.
// A 128-bit cipher key is captured on key_load, then round keys 0..NR are streamed
// one per accepted valid/ready transfer. Each key is computed on the fly from the
// previous one, so no key memory is held.
// Optional feature macro: KEY_DIR_EN adds the key_dir input. With key_dir=1 the
// loaded key is treated as the round-NR key and the schedule is walked backwards.

module aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  // Forward AES S-box, row 0x0_ first; entry x lives at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - x) * 8 is simply the inverted byte shifted left by three.
  logic [10:0] table_index;

  // Pure table lookup; no state in the S-box.
  always_comb begin
    table_index = {~in_byte, 3'b000};
    out_byte    = SBOX_TABLE[table_index +: 8];
  end

endmodule

module key_expand_128 #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] key_in,
`ifdef KEY_DIR_EN
  input  logic         key_dir,
`endif
  input  logic         rk_ready,
  output logic         rk_valid,
  output logic [127:0] round_key,
  output logic [3:0]   rk_round,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  // GF(2^8) multiply by x with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    xtime = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  // Inverse of xtime: an odd value can only come from a reduced (carry) step.
  function automatic logic [7:0] inv_xtime(input logic [7:0] a);
    logic [7:0] unreduced;
    unreduced = a ^ 8'h1b;
    inv_xtime = a[0] ? {1'b1, unreduced[7:1]} : {1'b0, a[7:1]};
  endfunction

  // Round constant used to derive round key r from round key r-1.
  function automatic logic [7:0] rcon_at_round(input int r);
    logic [7:0] acc;
    acc = 8'h01;
    for (int i = 1; i < r; i++) begin
      acc = xtime(acc);
    end
    rcon_at_round = acc;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    rot_word = {w[23:0], w[31:24]};
  endfunction

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [7:0] RCON_LAST  = rcon_at_round(NR);

  state_t         state_q, state_d;
  logic [127:0]   key_q, key_d;
  logic [3:0]     round_q, round_d;
  logic [7:0]     rcon_q, rcon_d;

`ifdef KEY_DIR_EN
  logic           dir_q, dir_d;
`else
  logic           dir_q;
  assign dir_q = 1'b0;
`endif

  logic [31:0]    w0, w1, w2, w3;
  logic [31:0]    w1p, w2p, w3p;
  logic [31:0]    sub_in, sub_out, t_word;
  logic [127:0]   next_key;
  logic [7:0]     next_rcon;
  logic           last_key;

  // Four byte S-boxes form SubWord; they are shared by the forward and reverse steps.
  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_byte  (sub_in[8*i +: 8]),
      .out_byte (sub_out[8*i +: 8])
    );
  end

  // One schedule step from the current key, in whichever direction was loaded.
  always_comb begin
    w0  = key_q[127:96];
    w1  = key_q[95:64];
    w2  = key_q[63:32];
    w3  = key_q[31:0];
    w3p = w3 ^ w2;
    w2p = w2 ^ w1;
    w1p = w1 ^ w0;
    sub_in = dir_q ? rot_word(w3p) : rot_word(w3);
    t_word = sub_out ^ {rcon_q, 24'h0};
    next_key = 128'h0;
    next_rcon = rcon_q;
    if (dir_q) begin
      next_key  = {w0 ^ t_word, w1p, w2p, w3p};
      next_rcon = (rcon_q == 8'h01) ? rcon_q : inv_xtime(rcon_q);
    end else begin
      next_key[127:96] = w0 ^ t_word;
      next_key[95:64]  = w1 ^ next_key[127:96];
      next_key[63:32]  = w2 ^ next_key[95:64];
      next_key[31:0]   = w3 ^ next_key[63:32];
      next_rcon        = xtime(rcon_q);
    end
    last_key = dir_q ? (round_q == 4'd0) : (round_q == LAST_ROUND);
  end

  // Next-state logic: a load always wins, otherwise a transfer advances the schedule.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    rcon_d  = rcon_q;
`ifdef KEY_DIR_EN
    dir_d   = dir_q;
`endif
    if (key_load) begin
      state_d = LOAD;
      key_d   = key_in;
`ifdef KEY_DIR_EN
      dir_d   = key_dir;
      round_d = key_dir ? LAST_ROUND : 4'd0;
      rcon_d  = key_dir ? RCON_LAST : 8'h01;
`else
      round_d = 4'd0;
      rcon_d  = 8'h01;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        LOAD, STREAM: begin
          if (rk_ready) begin
            if (last_key) begin
              state_d = IDLE;
            end else begin
              state_d = STREAM;
              key_d   = next_key;
              rcon_d  = next_rcon;
              round_d = dir_q ? (round_q - 4'd1) : (round_q + 4'd1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Schedule registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= 128'h0;
      round_q <= 4'd0;
      rcon_q  <= 8'h01;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
    end
  end

`ifdef KEY_DIR_EN
  // Direction is captured with the key and held for the whole schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
    end
  end
`endif

  // Outputs come straight from registers, so they are glitch-free for sigma.
  always_comb begin
    rk_valid  = (state_q != IDLE);
    busy      = (state_q != IDLE);
    round_key = key_q;
    rk_round  = round_q;
  end

endmodule

// File: tb/tb_key_expand_128.sv
// tb_key_expand_128: scoreboard bench for key_expand_128 (NR=10 and NR=1 instances).
// Stimulus pushes expected round keys into a queue; a negedge monitor pops on
// every transfer and checks held values during stalls.

module tb_key_expand_128;

  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_load, rk_ready, rk_valid, busy;
  logic [127:0] key_in, round_key;
  logic [3:0]   rk_round;
  logic         key_dir;

  logic         key_load1, rk_ready1, rk_valid1, busy1;
  logic [127:0] key_in1, round_key1;
  logic [3:0]   rk_round1;

  exp_t sbq[$];
  exp_t sbq1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   failures = 0;

  // FIPS-197 schedule of key 2b7e1516...
  logic [127:0] sched_a [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
  logic [127:0] key_b  = 128'h000102030405060708090a0b0c0d0e0f;
  logic [127:0] key_b10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  always #5 clk = ~clk;

  key_expand_128 #(.NR(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in),
`ifdef KEY_DIR_EN
    .key_dir(key_dir),
`endif
    .rk_ready(rk_ready), .rk_valid(rk_valid), .round_key(round_key),
    .rk_round(rk_round), .busy(busy));

  key_expand_128 #(.NR(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .key_load(key_load1), .key_in(key_in1),
`ifdef KEY_DIR_EN
    .key_dir(1'b0),
`endif
    .rk_ready(rk_ready1), .rk_valid(rk_valid1), .round_key(round_key1),
    .rk_round(rk_round1), .busy(busy1));

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One-cycle key_load pulse on the NR=10 instance, driven just after a rising edge.
  task automatic applyStimulus(input logic [127:0] key, input logic dir);
    key_in   = key;
    key_dir  = dir;
    key_load = 1'b1;
    @(posedge clk); #1;
    key_load = 1'b0;
  endtask

  task automatic pushForward(input logic [127:0] k0, input bit full);
    sbq.delete();
    for (int r = 0; r <= 10; r++) begin
      e0.rnd = 4'(r);
      e0.key = (r == 0) ? k0 : sched_a[r];
      e0.chk = full || (r == 0);
      sbq.push_back(e0);
    end
  endtask

  // Run until the scoreboard drains, optionally toggling ready as 1,0,0,1.
  task automatic waitDrain(input int budget, input bit toggle, output int cycles);
    logic [3:0] pat;
    pat = 4'b1001;
    cycles = 0;
    while (sbq.size() != 0 && cycles < budget) begin
      rk_ready = toggle ? pat[cycles % 4] : 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    rk_ready = 1'b1;
    if (sbq.size() != 0) begin
      checkOutput("drain_timeout", 128'(sbq.size()), 128'h0);
    end
  endtask

  task automatic waitRound(input logic [3:0] target);
    int n;
    n = 0;
    while (rk_round !== target && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("reach_round", {124'h0, rk_round}, {124'h0, target});
  endtask

  // Monitor for the NR=10 instance: check every presented key, pop on transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_load !== 1'b1 && rk_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        checkOutput("unexpected_valid", {127'h0, rk_valid}, 128'h0);
      end else begin
        e1 = sbq[0];
        checkOutput("rk_round", {124'h0, rk_round}, {124'h0, e1.rnd});
        checkOutput("busy", {127'h0, busy}, 128'h1);
        if (e1.chk) checkOutput("round_key", round_key, e1.key);
        if (rk_ready === 1'b1) void'(sbq.pop_front());
      end
    end
  end

  // Monitor for the NR=1 instance.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && key_load1 !== 1'b1 && rk_valid1 === 1'b1) begin
      if (sbq1.size() == 0) begin
        checkOutput("nr1_unexpected_valid", {127'h0, rk_valid1}, 128'h0);
      end else begin
        checkOutput("nr1_rk_round", {124'h0, rk_round1}, {124'h0, sbq1[0].rnd});
        checkOutput("nr1_round_key", round_key1, sbq1[0].key);
        if (rk_ready1 === 1'b1) void'(sbq1.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cyc;
    rst_n = 1'b0; key_load = 1'b0; rk_ready = 1'b0; key_in = '0; key_dir = 1'b0;
    key_load1 = 1'b0; rk_ready1 = 1'b0; key_in1 = '0;
    #1;
    checkOutput("reset_valid", {127'h0, rk_valid}, 128'h0);
    checkOutput("reset_key", round_key, 128'h0);
    checkOutput("reset_round", {124'h0, rk_round}, 128'h0);
    checkOutput("reset_busy", {127'h0, busy}, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] full stream, ready held high (also high during idle load)");
    rk_ready = 1'b1;
    pushForward(sched_a[0], 1'b1);
    applyStimulus(sched_a[0], 1'b0);
    checkOutput("latency_valid", {127'h0, rk_valid}, 128'h1);
    checkOutput("latency_key", round_key, sched_a[0]);
    waitDrain(40, 1'b0, cyc);
    checkOutput("stream_cycles", 128'(cyc), 128'd11);
    checkOutput("end_valid", {127'h0, rk_valid}, 128'h0);
    checkOutput("end_busy", {127'h0, busy}, 128'h0);
    repeat (3) @(posedge clk); #1;
    checkOutput("idle_ignores_ready", {127'h0, rk_valid}, 128'h0);

    $display("[TB] stream with ready toggling 1,0,0,1");
    pushForward(sched_a[0], 1'b1);
    applyStimulus(sched_a[0], 1'b0);
    waitDrain(80, 1'b1, cyc);
    checkOutput("stall_end_valid", {127'h0, rk_valid}, 128'h0);

    $display("[TB] reload at round 5 with ready high");
    pushForward(sched_a[0], 1'b1);
    applyStimulus(sched_a[0], 1'b0);
    waitRound(4'd5);
    sbq.delete();
    for (int r = 0; r <= 10; r++) begin
      e0.rnd = 4'(r);
      e0.key = (r == 0) ? key_b : key_b10;
      e0.chk = (r == 0) || (r == 10);
      sbq.push_back(e0);
    end
    applyStimulus(key_b, 1'b0);
    checkOutput("reload_round", {124'h0, rk_round}, 128'h0);
    checkOutput("reload_key", round_key, key_b);
    waitDrain(40, 1'b0, cyc);
    checkOutput("reload_cycles", 128'(cyc), 128'd11);

    $display("[TB] async reset at round 7");
    pushForward(sched_a[0], 1'b1);
    applyStimulus(sched_a[0], 1'b0);
    waitRound(4'd7);
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    checkOutput("midreset_valid", {127'h0, rk_valid}, 128'h0);
    checkOutput("midreset_key", round_key, 128'h0);
    checkOutput("midreset_round", {124'h0, rk_round}, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    checkOutput("post_reset_idle", {127'h0, rk_valid}, 128'h0);

`ifdef KEY_DIR_EN
    $display("[TB] reverse schedule from round-10 key");
    sbq.delete();
    for (int r = 10; r >= 0; r--) begin
      e0.rnd = 4'(r);
      e0.key = sched_a[r];
      e0.chk = 1'b1;
      sbq.push_back(e0);
    end
    applyStimulus(sched_a[10], 1'b1);
    waitDrain(40, 1'b0, cyc);
    checkOutput("rev_final_key", round_key, sched_a[0]);
    checkOutput("rev_end_valid", {127'h0, rk_valid}, 128'h0);
    key_dir = 1'b0;
`endif

    $display("[TB] NR=1 instance");
    for (int r = 0; r <= 1; r++) begin
      e0.rnd = 4'(r);
      e0.key = sched_a[r];
      e0.chk = 1'b1;
      sbq1.push_back(e0);
    end
    rk_ready1 = 1'b1;
    key_in1 = sched_a[0];
    key_load1 = 1'b1;
    @(posedge clk); #1;
    key_load1 = 1'b0;
    cyc = 0;
    while (sbq1.size() != 0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    checkOutput("nr1_cycles", 128'(cyc), 128'd2);
    checkOutput("nr1_end_valid", {127'h0, rk_valid1}, 128'h0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
